// File: rtl/calc_cmd_scheduler.sv
// -----------------------------------------------------------------------------
// calc_cmd_scheduler
//
// Purpose:
//   Buffers key codes from the keypad/debounce front end in a small FIFO and
//   issues them one at a time on the calculator core's 4-bit cmd bus. The
//   core's status handshake is 2'b10 ready, 2'b01 busy and 2'b00 error. Each
//   key reaches the core exactly once. Between commands the bus is parked on
//   IDLE_CMD.
//
// Parameters:
//   DEPTH       FIFO entries (power of two, >= 2)
//   IDLE_CMD    neutral code driven on cmd when no command is in flight
//   ACK_TIMEOUT cycles the core may stay ready after a command is presented
//               before that command is dropped (>= 1)
//
// Ports:
//   clock         system clock, rising edge
//   reset         asynchronous, active-high
//   key_valid     key code present this cycle
//   key_code      0-9 digit, 10-12 operator, 14 equals, 15 backspace
//   key_ready     FIFO can accept (not full, not in ERROR, out of reset)
//   calc_status   status from the calculator core
//   cmd           registered command to the core
//   fifo_count    current FIFO occupancy
//   overflow      sticky: a key was dropped because the FIFO was full
//   ack_timeout   sticky: a command was dropped because the core never went busy
//   calc_err      high while in ERROR (left only by reset)
//   issued_count  commands acknowledged by the core, wraps 255 -> 0
//
// Build option:
//   CALC_SCHED_BKSP_MERGE_EN  when defined, a backspace pushed while the
//   newest queued entry is a digit removes that digit instead of being
//   queued. When undefined, backspace is queued like any other code.
// -----------------------------------------------------------------------------
module calc_cmd_scheduler #(
  parameter int unsigned DEPTH       = 8,
  parameter logic [3:0]  IDLE_CMD    = 4'hD,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   key_valid,
  input  logic [3:0]             key_code,
  output logic                   key_ready,
  input  logic [1:0]             calc_status,
  output logic [3:0]             cmd,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
  output logic                   ack_timeout,
  output logic                   calc_err,
  output logic [7:0]             issued_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned TMO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  localparam logic [1:0] STAT_ERROR = 2'b00;
  localparam logic [1:0] STAT_BUSY  = 2'b01;
  localparam logic [1:0] STAT_READY = 2'b10;

  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
  localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_READY,
    ST_ERROR
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       cmd_q, cmd_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [7:0]       issued_q, issued_d;
  logic             overflow_q, overflow_d;
  logic             ack_tmo_q, ack_tmo_d;
  logic             rst_done_q;

  logic [3:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic fifo_empty;
  logic fifo_full;
  logic ready_int;
  logic push_req;
  logic do_pop;
  logic do_write;
  logic do_merge;
  logic flush;

`ifdef CALC_SCHED_BKSP_MERGE_EN
  logic [PTR_W-1:0] newest_ptr;
`endif

  // ---------------------------------------------------------------------------
  // Issue FSM: next state, command register and handshake bookkeeping.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_d   = state_q;
    cmd_d     = cmd_q;
    tmo_d     = tmo_q;
    issued_d  = issued_q;
    ack_tmo_d = ack_tmo_q;
    do_pop    = 1'b0;

    // A core error outranks every other transition, from any live state.
    if (state_q != ST_ERROR && calc_status == STAT_ERROR) begin
      state_d = ST_ERROR;
      cmd_d   = IDLE_CMD;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          cmd_d = IDLE_CMD;
          if (!fifo_empty && calc_status == STAT_READY) begin
            do_pop  = 1'b1;
            cmd_d   = mem_q[rd_ptr_q];
            tmo_d   = '0;
            state_d = ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // Anything but busy counts as "not yet acknowledged", so an
          // undefined 2'b11 status cannot stall the bus forever.
          if (calc_status == STAT_BUSY) begin
            state_d = ST_WAIT_READY;
          end else if (tmo_q == TMO_LAST) begin
            ack_tmo_d = 1'b1;
            cmd_d     = IDLE_CMD;
            state_d   = ST_IDLE;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
        ST_WAIT_READY: begin
          // cmd is held for the entire busy period, however long.
          if (calc_status == STAT_READY) begin
            cmd_d    = IDLE_CMD;
            issued_d = issued_q + 8'd1;
            state_d  = ST_IDLE;
          end
        end
        ST_ERROR: begin
          cmd_d = IDLE_CMD;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO control: push, pop, optional backspace merge, flush on error.
  // ---------------------------------------------------------------------------
  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == FULL_COUNT);
    // A full FIFO rejects a push even when a pop happens in the same cycle.
    ready_int  = rst_done_q && !fifo_full && (state_q != ST_ERROR);
    push_req   = key_valid && ready_int;
    flush      = (state_d == ST_ERROR);
    do_merge   = 1'b0;

`ifdef CALC_SCHED_BKSP_MERGE_EN
    newest_ptr = wr_ptr_q - 1'b1;
    // The newest entry can only be cancelled if it is not leaving the FIFO
    // this cycle; when it is, the backspace is queued normally.
    if (push_req && key_code == 4'hF && !fifo_empty &&
        mem_q[newest_ptr] <= 4'd9 &&
        !(do_pop && count_q == CNT_W'(1))) begin
      do_merge = 1'b1;
    end
`endif

    do_write = push_req && !do_merge && !flush;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q;
      if (do_merge) begin
        wr_ptr_d = wr_ptr_q - 1'b1;
      end else if (do_write) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q + CNT_W'(do_write) - CNT_W'(do_pop) - CNT_W'(do_merge);
    end

    // Dropped keys are only reported while the scheduler is live.
    overflow_d = overflow_q |
                 (key_valid && !ready_int && rst_done_q && state_q != ST_ERROR);
  end

  // ---------------------------------------------------------------------------
  // State registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cmd_q      <= IDLE_CMD;
      tmo_q      <= '0;
      issued_q   <= '0;
      overflow_q <= 1'b0;
      ack_tmo_q  <= 1'b0;
      rst_done_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values regardless of statement order.
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      tmo_q      <= tmo_d;
      issued_q   <= issued_d;
      overflow_q <= overflow_d;
      ack_tmo_q  <= ack_tmo_d;
      rst_done_q <= 1'b1;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // NOTE: the storage array has no reset; the pointers and count define which
  // entries are valid, so stale contents are never observed.
  always_ff @(posedge clock) begin
    if (do_write) begin
      mem_q[wr_ptr_q] <= key_code;
    end
  end

  assign key_ready    = ready_int;
  assign cmd          = cmd_q;
  assign fifo_count   = count_q;
  assign overflow     = overflow_q;
  assign ack_timeout  = ack_tmo_q;
  assign calc_err     = (state_q == ST_ERROR);
  assign issued_count = issued_q;

endmodule
